// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - control sequencer for three-register ALU instructions
module alu_op_sequencer #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] ir,
   input  logic                  mem_ack,
   output logic                  mem_rd,
   output logic                  pco,
   output logic                  pci,
   output logic                  inc_pc,
   output logic                  mari,
   output logic                  mdri,
   output logic                  mdro,
   output logic                  iri,
   output logic                  ryi,
   output logic                  zi,
   output logic                  zlo,
   output logic [1:0]            alu_op,
   output logic [NUM_REGS-1:0]   reg_out,
   output logic [NUM_REGS-1:0]   reg_in,
   output logic                  busy,
   output logic                  done,
   output logic                  illegal,
   output logic                  bus_error
);

   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, ERR} state_t;

   localparam logic [NUM_REGS-1:0] REG_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

   state_t     state, state_next;
   logic [7:0] wait_cnt, wait_cnt_next;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic [1:0] dec_op;
   logic       op_legal;
   logic       regs_legal;
   logic       unused_ir;

   assign opcode    = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir;

   assign regs_legal = ({1'b0, ra} < 5'(NUM_REGS)) &&
                       ({1'b0, rb} < 5'(NUM_REGS)) &&
                       ({1'b0, rc} < 5'(NUM_REGS));

   // opcode to ALU function; anything not listed is an illegal instruction
   always_comb begin
      op_legal = 1'b1;
      dec_op   = 2'b00;
      case (opcode)
         5'b00011: dec_op = 2'b00;
         5'b00100: dec_op = 2'b01;
         5'b00101: dec_op = 2'b10;
         5'b01011: dec_op = 2'b11;
         default:  op_legal = 1'b0;
      endcase
   end

   // state register and memory wait counter
   always_ff @(posedge clock) begin
      if (clear) begin
         state    <= IDLE;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // next state and strobe decode from the registered state
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      mem_rd        = 1'b0;
      pco           = 1'b0;
      pci           = 1'b0;
      inc_pc        = 1'b0;
      mari          = 1'b0;
      mdri          = 1'b0;
      mdro          = 1'b0;
      iri           = 1'b0;
      ryi           = 1'b0;
      zi            = 1'b0;
      zlo           = 1'b0;
      alu_op        = 2'b00;
      reg_out       = '0;
      reg_in        = '0;
      done          = 1'b0;
      illegal       = 1'b0;
      bus_error     = 1'b0;
      busy          = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) state_next = T0;
         end
         T0: begin
            pco           = 1'b1;
            mari          = 1'b1;
            inc_pc        = 1'b1;
            zi            = 1'b1;
            wait_cnt_next = 8'd0;
            state_next    = T1;
         end
         T1: begin
            // PC+1 is written back once; later wait cycles only hold the request
            mem_rd = 1'b1;
            if (wait_cnt == 8'd0) begin
               zlo = 1'b1;
               pci = 1'b1;
            end
            if (mem_ack) begin
               mdri       = 1'b1;
               state_next = T2;
            end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
               state_next = ERR;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
            end
         end
         T2: begin
            mdro       = 1'b1;
            iri        = 1'b1;
            state_next = T3;
         end
         T3: begin
            if (op_legal && regs_legal) begin
               reg_out    = REG_ONE << rb;
               ryi        = 1'b1;
               state_next = T4;
            end else begin
               illegal    = 1'b1;
               state_next = IDLE;
            end
         end
         T4: begin
            reg_out    = REG_ONE << rc;
            alu_op     = dec_op;
            zi         = 1'b1;
            state_next = T5;
         end
         T5: begin
            zlo        = 1'b1;
            reg_in     = REG_ONE << ra;
            done       = 1'b1;
            state_next = IDLE;
         end
         ERR: begin
            bus_error  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer
module tb_alu_op_sequencer;

   logic        clock = 1'b0;
   logic        clear, start, mem_ack;
   logic [31:0] ir;

   logic        mem_rd, pco, pci, inc_pc, mari, mdri, mdro, iri, ryi, zi, zlo;
   logic [1:0]  alu_op;
   logic [15:0] reg_out, reg_in;
   logic        busy, done, illegal, bus_error;

   logic        b_mem_rd, b_pco, b_pci, b_inc_pc, b_mari, b_mdri, b_mdro, b_iri, b_ryi, b_zi, b_zlo;
   logic [1:0]  b_alu_op;
   logic [7:0]  b_reg_out, b_reg_in;
   logic        b_busy, b_done, b_illegal, b_bus_error;

   int total = 0;
   int bad = 0;
   int busy_cycles = 0;

   always #5 clock = ~clock;

   alu_op_sequencer #(.DATA_WIDTH(32), .NUM_REGS(16), .MEM_TIMEOUT(15)) dut (
      .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ack(mem_ack),
      .mem_rd(mem_rd), .pco(pco), .pci(pci), .inc_pc(inc_pc), .mari(mari),
      .mdri(mdri), .mdro(mdro), .iri(iri), .ryi(ryi), .zi(zi), .zlo(zlo),
      .alu_op(alu_op), .reg_out(reg_out), .reg_in(reg_in), .busy(busy),
      .done(done), .illegal(illegal), .bus_error(bus_error)
   );

   alu_op_sequencer #(.DATA_WIDTH(32), .NUM_REGS(8), .MEM_TIMEOUT(15)) dut8 (
      .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ack(mem_ack),
      .mem_rd(b_mem_rd), .pco(b_pco), .pci(b_pci), .inc_pc(b_inc_pc), .mari(b_mari),
      .mdri(b_mdri), .mdro(b_mdro), .iri(b_iri), .ryi(b_ryi), .zi(b_zi), .zlo(b_zlo),
      .alu_op(b_alu_op), .reg_out(b_reg_out), .reg_in(b_reg_in), .busy(b_busy),
      .done(b_done), .illegal(b_illegal), .bus_error(b_bus_error)
   );

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
      return {op, a, b, c, 15'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // mid-cycle: count busy cycles and confirm a single bus driver
   always @(negedge clock) begin
      automatic int drivers;
      if (busy) busy_cycles++;
      if (!clear) begin
         drivers = int'(pco) + int'(mdro) + int'(zlo) + $countones(reg_out);
         total++;
         assert (drivers <= 1) else begin
            bad++;
            $error("FAIL bus_drivers observed=%0d expected<=1", drivers);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 1'b1; start = 1'b0; mem_ack = 1'b0; ir = 32'd0;
      tick(); tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_reg_out", 32'(reg_out), 32'd0);
      chk("rst_zi", 32'(zi), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      clear = 1'b0;

      // OR R3,R0,R1 with mem_ack tied high
      ir = mk(5'b01011, 4'd3, 4'd0, 4'd1); mem_ack = 1'b1; start = 1'b1;
      busy_cycles = 0;
      tick(); start = 1'b0; #1;
      chk("or_t0_pco", 32'(pco), 32'd1);
      chk("or_t0_mari", 32'(mari), 32'd1);
      chk("or_t0_inc", 32'(inc_pc), 32'd1);
      chk("or_t0_zi", 32'(zi), 32'd1);
      tick();
      chk("or_t1_mem_rd", 32'(mem_rd), 32'd1);
      chk("or_t1_pci", 32'(pci), 32'd1);
      chk("or_t1_zlo", 32'(zlo), 32'd1);
      chk("or_t1_mdri", 32'(mdri), 32'd1);
      tick();
      chk("or_t2_mdro", 32'(mdro), 32'd1);
      chk("or_t2_iri", 32'(iri), 32'd1);
      tick();
      chk("or_t3_reg_out", 32'(reg_out), 32'h0001);
      chk("or_t3_ryi", 32'(ryi), 32'd1);
      tick();
      chk("or_t4_reg_out", 32'(reg_out), 32'h0002);
      chk("or_t4_alu_op", 32'(alu_op), 32'd3);
      chk("or_t4_zi", 32'(zi), 32'd1);
      chk("or_t4_inc", 32'(inc_pc), 32'd0);
      tick();
      chk("or_t5_reg_in", 32'(reg_in), 32'h0008);
      chk("or_t5_zlo", 32'(zlo), 32'd1);
      chk("or_t5_done", 32'(done), 32'd1);
      tick();
      chk("or_idle_busy", 32'(busy), 32'd0);
      chk("or_idle_done", 32'(done), 32'd0);
      @(negedge clock); #1;
      chk("or_busy_cycles", 32'(busy_cycles), 32'd6);

      // ADD R2,R5,R6 with mem_ack three cycles late
      ir = mk(5'b00011, 4'd2, 4'd5, 4'd6); mem_ack = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      tick();
      chk("dly_c2_pci", 32'(pci), 32'd1);
      chk("dly_c2_mdri", 32'(mdri), 32'd0);
      chk("dly_c2_mem_rd", 32'(mem_rd), 32'd1);
      tick();
      chk("dly_c3_pci", 32'(pci), 32'd0);
      chk("dly_c3_mdri", 32'(mdri), 32'd0);
      tick();
      chk("dly_c4_mdri", 32'(mdri), 32'd0);
      chk("dly_c4_iri", 32'(iri), 32'd0);
      tick(); mem_ack = 1'b1; #1;
      chk("dly_c5_mdri", 32'(mdri), 32'd1);
      chk("dly_c5_pci", 32'(pci), 32'd0);
      tick(); mem_ack = 1'b0; #1;
      chk("dly_c6_iri", 32'(iri), 32'd1);
      tick();
      chk("dly_c7_reg_out", 32'(reg_out), 32'h0020);
      tick();
      chk("dly_c8_reg_out", 32'(reg_out), 32'h0040);
      chk("dly_c8_alu_op", 32'(alu_op), 32'd0);
      tick();
      chk("dly_c9_done", 32'(done), 32'd1);
      chk("dly_c9_reg_in", 32'(reg_in), 32'h0004);
      tick();
      chk("dly_idle_busy", 32'(busy), 32'd0);

      // mem_ack never arrives
      ir = mk(5'b01011, 4'd3, 4'd0, 4'd1); mem_ack = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("to_t1_mem_rd", 32'(mem_rd), 32'd1);
         chk("to_t1_bus_error", 32'(bus_error), 32'd0);
         chk("to_t1_iri", 32'(iri), 32'd0);
      end
      tick();
      chk("to_err_bus_error", 32'(bus_error), 32'd1);
      chk("to_err_iri", 32'(iri), 32'd0);
      chk("to_err_reg_in", 32'(reg_in), 32'd0);
      tick();
      chk("to_idle_busy", 32'(busy), 32'd0);
      chk("to_idle_bus_error", 32'(bus_error), 32'd0);

      // bad opcode
      ir = mk(5'b11111, 4'd1, 4'd2, 4'd3); mem_ack = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      chk("ill_t3_illegal", 32'(illegal), 32'd1);
      chk("ill_t3_ryi", 32'(ryi), 32'd0);
      chk("ill_t3_zi", 32'(zi), 32'd0);
      chk("ill_t3_reg_in", 32'(reg_in), 32'd0);
      chk("ill_t3_reg_out", 32'(reg_out), 32'd0);
      tick();
      chk("ill_idle_busy", 32'(busy), 32'd0);
      chk("ill_idle_illegal", 32'(illegal), 32'd0);

      // clear in T4 with start raised the same cycle
      ir = mk(5'b01011, 4'd3, 4'd0, 4'd1); mem_ack = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick(); tick();
      chk("clr_t4_zi", 32'(zi), 32'd1);
      clear = 1'b1; start = 1'b1;
      tick(); clear = 1'b0; start = 1'b0; #1;
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_reg_out", 32'(reg_out), 32'd0);
      chk("clr_zi", 32'(zi), 32'd0);
      tick();
      chk("clr_start_ignored", 32'(busy), 32'd0);

      // NUM_REGS=8: ADD R9,R1,R2 is illegal there, legal on the 16-register copy
      ir = mk(5'b00011, 4'd9, 4'd1, 4'd2); mem_ack = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      chk("r8_ill_illegal", 32'(b_illegal), 32'd1);
      chk("r8_ill_ryi", 32'(b_ryi), 32'd0);
      chk("r16_legal_ryi", 32'(ryi), 32'd1);
      chk("r16_legal_illegal", 32'(illegal), 32'd0);
      tick();
      chk("r8_ill_idle", 32'(b_busy), 32'd0);
      tick();
      chk("r16_r9_reg_in", 32'(reg_in), 32'h0200);
      tick();
      chk("r16_idle", 32'(busy), 32'd0);

      // ADD R7,R1,R2 on both
      ir = mk(5'b00011, 4'd7, 4'd1, 4'd2); start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      chk("r8_r7_reg_in", 32'(b_reg_in), 32'h80);
      chk("r8_r7_done", 32'(b_done), 32'd1);
      chk("r16_r7_reg_in", 32'(reg_in), 32'h0080);
      tick();
      chk("r8_r7_idle", 32'(b_busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
